// File: rtl/dma_rd_data.sv
// DMA read-data stage: accepts AXI R beats, checks them against the 256-beat burst split,
// and buffers them in a show-ahead FIFO feeding a valid/ready stream with a last marker.
module dma_rd_data #(
    parameter int ID_WIDTH   = 4,
    parameter int DATA_WIDTH = 64,
    parameter int SIZE_WIDTH = 16,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ID_WIDTH-1:0]   src_id,
    input  logic [SIZE_WIDTH-1:0] size,
    output logic                  busy,
    output logic                  done,
    output logic [2:0]            err_code,
    input  logic [ID_WIDTH-1:0]   M_AXI_RID,
    input  logic [DATA_WIDTH-1:0] M_AXI_RDATA,
    input  logic [1:0]            M_AXI_RRESP,
    input  logic                  M_AXI_RLAST,
    input  logic                  M_AXI_RVALID,
    output logic                  M_AXI_RREADY,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RECV  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]            r_state;
    logic [ID_WIDTH-1:0]   r_id;
    logic [SIZE_WIDTH-1:0] r_size;
    logic [SIZE_WIDTH-1:0] r_beat_cnt;
    logic [2:0]            r_err;
    logic                  r_done;
    logic [DATA_WIDTH:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [AW:0]           r_count;

    logic                  w_start;
    logic                  w_full;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_final_beat;
    logic                  w_exp_last;
    logic                  w_last_pop;
    logic [DATA_WIDTH:0]   w_head;

    assign w_start      = (r_state == S_IDLE) && start;
    assign w_full       = (r_count == FULL_CNT);
    assign M_AXI_RREADY = (r_state == S_RECV) && !w_full;
    assign w_push       = M_AXI_RVALID && M_AXI_RREADY;
    assign out_valid    = (r_count != '0);
    assign w_pop        = out_valid && out_ready;
    assign w_head       = r_mem[r_rd_ptr];
    // Head is masked while empty so the stream reads zero out of reset.
    assign out_data     = out_valid ? w_head[DATA_WIDTH-1:0] : '0;
    assign out_last     = out_valid && w_head[DATA_WIDTH];
    assign w_final_beat = (r_beat_cnt == r_size);
    assign w_exp_last   = (r_beat_cnt[7:0] == 8'hFF) || w_final_beat;
    assign w_last_pop   = (r_state == S_DRAIN) && w_pop && out_last;
    assign busy         = (r_state != S_IDLE);
    assign done         = r_done;
    assign err_code     = r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_id       <= '0;
            r_size     <= '0;
            r_beat_cnt <= '0;
            r_err      <= '0;
            r_done     <= 1'b0;
        end else begin
            r_done <= w_last_pop;
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_id       <= src_id;
                        r_size     <= size;
                        r_beat_cnt <= '0;
                        r_err      <= '0;
                        r_state    <= S_RECV;
                    end
                end
                S_RECV: begin
                    if (w_push) begin
                        r_beat_cnt <= r_beat_cnt + SIZE_WIDTH'(1);
                        r_err      <= r_err | {M_AXI_RID != r_id,
                                               M_AXI_RLAST != w_exp_last,
                                               M_AXI_RRESP != 2'b00};
                        if (w_final_beat) begin
                            r_state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_last_pop) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset; validity is tracked solely by the pointers and count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {w_final_beat, M_AXI_RDATA};
        end
    end

endmodule

// File: tb/tb_dma_rd_data.sv
// Bench for dma_rd_data: scenario table plus randomized transfers, each checked
// cycle by cycle against a queue-based model of the beat stream.
module tb_dma_rd_data;

    localparam int IDW   = 4;
    localparam int DW    = 64;
    localparam int SW    = 16;
    localparam int DEPTH = 16;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic [IDW-1:0] src_id = '0;
    logic [SW-1:0]  size = '0;
    logic           busy;
    logic           done;
    logic [2:0]     err_code;
    logic [IDW-1:0] M_AXI_RID = '0;
    logic [DW-1:0]  M_AXI_RDATA = '0;
    logic [1:0]     M_AXI_RRESP = '0;
    logic           M_AXI_RLAST = 1'b0;
    logic           M_AXI_RVALID = 1'b0;
    logic           M_AXI_RREADY;
    logic [DW-1:0]  out_data;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic           out_last;

    dma_rd_data #(
        .ID_WIDTH  (IDW),
        .DATA_WIDTH(DW),
        .SIZE_WIDTH(SW),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .src_id      (src_id),
        .size        (size),
        .busy        (busy),
        .done        (done),
        .err_code    (err_code),
        .M_AXI_RID   (M_AXI_RID),
        .M_AXI_RDATA (M_AXI_RDATA),
        .M_AXI_RRESP (M_AXI_RRESP),
        .M_AXI_RLAST (M_AXI_RLAST),
        .M_AXI_RVALID(M_AXI_RVALID),
        .M_AXI_RREADY(M_AXI_RREADY),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_last    (out_last)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
        end
    endtask

    // -1 in a beat field means "no fault injected"; -1 in an expectation means "model only".
    typedef struct {
        int size;
        int id;
        int vpct;
        int rpct;
        int resp_b;
        int last_b;
        int idb_b;
        int hold;
        int mid_start;
        int exp_err;
        int exp_beats;
    } scen_t;

    scen_t tbl[8];

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // Entered and left at a falling edge; leaves while done is high.
    task automatic run(input scen_t s, input string tag);
        logic [DW:0] q[$];
        int          total    = s.size + 1;
        int          accepted = 0;
        int          outs     = 0;
        int          cyc      = 0;
        int          obs_acc  = 0;
        int          b;
        bit          recv     = 1'b1;
        bit          e_done   = 1'b0;
        bit          e_busy   = 1'b1;
        bit          fin      = 1'b0;
        bit          pend     = 1'b0;
        bit          e_rready, e_valid, acc, pop, e_lastb;
        logic [2:0]  e_err    = '0;

        start        = 1'b1;
        src_id       = IDW'(s.id);
        size         = SW'(s.size);
        M_AXI_RVALID = 1'b0;
        out_ready    = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        while (!fin && cyc < 30000) begin
            e_rready = recv && (q.size() < DEPTH);
            e_valid  = (q.size() != 0);
            chk({tag, " rready"}, M_AXI_RREADY, e_rready);
            chk({tag, " out_valid"}, out_valid, e_valid);
            if (e_valid) begin
                chk({tag, " out_data"}, out_data, q[0][DW-1:0]);
                chk({tag, " out_last"}, out_last, q[0][DW]);
            end
            chk({tag, " done"}, done, e_done);
            chk({tag, " busy"}, busy, e_busy);
            chk({tag, " err_code"}, err_code, e_err);
            if (s.hold > 0 && cyc == s.hold && s.vpct == 100)
                chk({tag, " accepts_during_hold"}, obs_acc, imin(s.hold, imin(DEPTH, total)));
            if (e_done) begin
                fin = 1'b1;
            end else begin
                start = (cyc == s.mid_start);
                if (start) begin
                    size   = '0;
                    src_id = ~IDW'(s.id);
                end
                b = accepted;
                if (!pend) begin
                    M_AXI_RDATA  = {$urandom, $urandom};
                    M_AXI_RVALID = recv && ($urandom_range(99) < s.vpct);
                end
                M_AXI_RID   = (b == s.idb_b) ? IDW'(s.id ^ 7) : IDW'(s.id);
                M_AXI_RRESP = (b == s.resp_b) ? 2'd2 : 2'd0;
                e_lastb     = ((b % 256) == 255) || (b == s.size);
                M_AXI_RLAST = e_lastb ^ (b == s.last_b);
                out_ready   = (cyc < s.hold) ? 1'b0 : ($urandom_range(99) < s.rpct);

                acc  = M_AXI_RVALID && e_rready;
                pop  = e_valid && out_ready;
                if (M_AXI_RVALID && M_AXI_RREADY) obs_acc++;
                pend   = M_AXI_RVALID && !acc;
                e_done = pop && q[0][DW];
                if (pop) begin
                    void'(q.pop_front());
                    outs++;
                end
                if (acc) begin
                    q.push_back({(b == s.size), M_AXI_RDATA});
                    e_err |= {M_AXI_RID != IDW'(s.id), M_AXI_RLAST != e_lastb, M_AXI_RRESP != 2'd0};
                    accepted++;
                    if (accepted == total) recv = 1'b0;
                end
                e_busy = !e_done;
                @(posedge clk);
                @(negedge clk);
                cyc++;
            end
        end
        start        = 1'b0;
        M_AXI_RVALID = 1'b0;
        out_ready    = 1'b0;
        if (!fin) begin
            checks++;
            failures++;
            $display("FAIL %s timeout actual=no_done expected=done", tag);
        end
        if (s.exp_beats >= 0) chk({tag, " beats_out"}, outs, s.exp_beats);
        if (s.exp_err >= 0) chk({tag, " final_err"}, err_code, s.exp_err);
    endtask

    initial begin
        scen_t r;
        tbl[0] = '{3,   2, 100, 100, -1, -1, -1, 0, -1, 0, 4};
        tbl[1] = '{511, 1, 100, 100, -1, -1, -1, 0, -1, 0, 512};
        tbl[2] = '{7,   2, 100, 100,  2,  7,  4, 0, -1, 7, 8};
        tbl[3] = '{0,   3, 100, 100, -1, -1, -1, 0, -1, 0, 1};
        tbl[4] = '{300, 9,  70,  60, -1, -1, -1, 0, -1, 0, 301};
        tbl[5] = '{20,  4,  80, 100,  0, -1, -1, 0,  5, 1, 21};
        tbl[6] = '{10,  0, 100,  50, -1,  5, -1, 0, -1, 2, 11};
        tbl[7] = '{255, 7, 100,  90, -1, -1, 100, 0, -1, 4, 256};

        #2;
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset err", err_code, 0);
        chk("reset rready", M_AXI_RREADY, 0);
        chk("reset out_valid", out_valid, 0);
        chk("reset out_data", out_data, 0);
        chk("reset out_last", out_last, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) run(tbl[i], $sformatf("tbl%0d", i));

        // Backpressure: FIFO fills at 16 with 20 beats offered, then drains in order.
        r = '{19, 6, 100, 100, -1, -1, -1, 25, -1, 0, 20};
        run(r, "full_stall");
        // Build occupancy 8, then push and pop together across pointer wrap.
        r = '{40, 11, 100, 100, -1, -1, -1, 8, -1, 0, 41};
        run(r, "push_pop_occ8");

        for (int i = 0; i < 4; i++) begin
            r.size      = $urandom_range(600);
            r.id        = $urandom_range(15);
            r.vpct      = $urandom_range(100, 30);
            r.rpct      = $urandom_range(100, 30);
            r.resp_b    = ($urandom_range(2) == 0) ? $urandom_range(r.size) : -1;
            r.last_b    = ($urandom_range(2) == 0) ? $urandom_range(r.size) : -1;
            r.idb_b     = ($urandom_range(2) == 0) ? $urandom_range(r.size) : -1;
            r.hold      = $urandom_range(20);
            r.mid_start = $urandom_range(50);
            r.exp_err   = -1;
            r.exp_beats = r.size + 1;
            run(r, $sformatf("rand%0d", i));
        end

        // Reset in the middle of a transfer with data buffered.
        start  = 1'b1;
        size   = SW'(50);
        src_id = IDW'(3);
        @(posedge clk);
        @(negedge clk);
        start        = 1'b0;
        M_AXI_RVALID = 1'b1;
        M_AXI_RID    = IDW'(3);
        M_AXI_RRESP  = 2'd0;
        M_AXI_RLAST  = 1'b0;
        M_AXI_RDATA  = 64'hDEAD_BEEF_0000_0001;
        out_ready    = 1'b0;
        repeat (5) @(negedge clk);
        chk("midrst pre busy", busy, 1);
        chk("midrst pre out_valid", out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst busy", busy, 0);
        chk("midrst out_valid", out_valid, 0);
        chk("midrst rready", M_AXI_RREADY, 0);
        chk("midrst out_data", out_data, 0);
        chk("midrst done", done, 0);
        M_AXI_RVALID = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run(tbl[0], "after_reset");

        @(posedge clk);
        @(negedge clk);
        chk("final done_single_pulse", done, 0);
        chk("final busy", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
